// File: rtl/iob_reg_file_2r1w.sv
// Two-read/one-write register file with per-column write enables and a sweep clear engine.
// Define IOB_REG_FILE_BYPASS_EN for write-first forwarding on same-address read/write.

module iob_reg_file_col #(
  parameter int ADDR_WIDTH = 4,
  parameter int COL_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  busy,
  input  logic [ADDR_WIDTH-1:0] ptr,
  input  logic                  w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [COL_WIDTH-1:0]  w_data,
  input  logic                  r0_en,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r1_en,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic [COL_WIDTH-1:0]  r0_data,
  output logic [COL_WIDTH-1:0]  r1_data
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // No reset on the array itself so it can map onto distributed RAM.
  logic [COL_WIDTH-1:0] mem [DEPTH];
  logic                 r0_fwd, r1_fwd;
  logic [COL_WIDTH-1:0] r0_next, r1_next;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (busy)      mem[ptr]    <= '0;
      else if (w_en) mem[w_addr] <= w_data;
    end
  end

`ifdef IOB_REG_FILE_BYPASS_EN
  assign r0_fwd = w_en && (r0_addr == w_addr);
  assign r1_fwd = w_en && (r1_addr == w_addr);
`else
  assign r0_fwd = 1'b0;
  assign r1_fwd = 1'b0;
`endif

  assign r0_next = busy ? '0 : (r0_fwd ? w_data : mem[r0_addr]);
  assign r1_next = busy ? '0 : (r1_fwd ? w_data : mem[r1_addr]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_data <= '0;
      r1_data <= '0;
    end else begin
      if (r0_en) r0_data <= r0_next;
      if (r1_en) r1_data <= r1_next;
    end
  end
endmodule

module iob_reg_file_2r1w #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  busy,
  input  logic [NUM_COL-1:0]    w_en,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  r0_en,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic [DATA_WIDTH-1:0] r0_data,
  input  logic                  r1_en,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic [DATA_WIDTH-1:0] r1_data
);
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + ADDR_WIDTH'(1);
          if (ptr == {ADDR_WIDTH{1'b1}}) state <= IDLE;
        end
        default: begin
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
      endcase
    end
  end

  assign busy = (state == CLEAR);

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    iob_reg_file_col #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .COL_WIDTH (COL_WIDTH)
    ) u_col (
      .clk    (clk),
      .rst_n  (rst_n),
      .busy   (busy),
      .ptr    (ptr),
      .w_en   (w_en[c]),
      .w_addr (w_addr),
      .w_data (w_data[COL_WIDTH*c +: COL_WIDTH]),
      .r0_en  (r0_en),
      .r0_addr(r0_addr),
      .r1_en  (r1_en),
      .r1_addr(r1_addr),
      .r0_data(r0_data[COL_WIDTH*c +: COL_WIDTH]),
      .r1_data(r1_data[COL_WIDTH*c +: COL_WIDTH])
    );
  end
endmodule
